fpu_uart_sequencer: RTL and testbench

//  Command controller between the UART receive/transmit paths and the 16-bit FPU.

---
 rtl/fpu_uart_pkg.sv | 16 +
 rtl/fpu_uart_sequencer_if.sv | 22 ++
 rtl/seq_timeout_cnt.sv | 16 +
 rtl/fpu_uart_sequencer.sv | 81 ++++++++
 tb/tb_fpu_uart_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fpu_uart_pkg.sv
// fpu_uart_pkg: opcode, FSM state and response constants shared by the UART/FPU sequencer
package fpu_uart_pkg;
  typedef enum logic [1:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV} fpu_op_t;
  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GET_AH   = 4'd1;
  localparam logic [3:0] S_GET_AL   = 4'd2;
  localparam logic [3:0] S_GET_BH   = 4'd3;
  localparam logic [3:0] S_GET_BL   = 4'd4;
  localparam logic [3:0] S_EXEC     = 4'd5;
  localparam logic [3:0] S_WAIT_FPU = 4'd6;
  localparam logic [3:0] S_TX_RH    = 4'd7;
  localparam logic [3:0] S_TX_RL    = 4'd8;
  localparam logic [3:0] S_TX_FL    = 4'd9;
  localparam logic [3:0] S_TX_ERR   = 4'd10;
  localparam int RESP_BYTES = 3;
endpackage

// File: rtl/fpu_uart_sequencer_if.sv
// fpu_uart_sequencer_if: UART rx/tx, FPU handshake and status signals of the sequencer
interface fpu_uart_sequencer_if;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic        fpu_start;
  logic [1:0]  fpu_op;
  logic [15:0] fpu_a;
  logic [15:0] fpu_b;
  logic        fpu_done;
  logic [15:0] fpu_result;
  logic [3:0]  fpu_flags;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic        err_timeout;
  logic        err_overrun;
  modport master(input rx_flag, rx_data, fpu_done, fpu_result, fpu_flags, tx_done,
                 output fpu_start, fpu_op, fpu_a, fpu_b, tx_start, tx_data, busy, err_timeout, err_overrun);
  modport slave(output rx_flag, rx_data, fpu_done, fpu_result, fpu_flags, tx_done,
                input fpu_start, fpu_op, fpu_a, fpu_b, tx_start, tx_data, busy, err_timeout, err_overrun);
endinterface

// File: rtl/seq_timeout_cnt.sv
// seq_timeout_cnt: inter-byte cycle counter that saturates at its terminal count
module seq_timeout_cnt #(
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = $clog2(TIMEOUT_CYC);
  logic [W-1:0] cnt;
  assign tc = cnt == W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (en && !tc) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/fpu_uart_sequencer.sv
// fpu_uart_sequencer: collects a 5-byte UART command frame, launches the FPU, streams a 3-byte response
module fpu_uart_sequencer
  import fpu_uart_pkg::*;
#(
  parameter int         TIMEOUT_CYC = 1_000_000,
  parameter logic [7:0] ERR_BYTE    = 8'hEE
) (
  input logic clk,
  input logic rst,
  fpu_uart_sequencer_if.master bus
);
  logic [3:0] state;
  logic rx_prev, ev, tc, in_get;
  logic [7:0] rx_byte;
  logic [RESP_BYTES-1:0][7:0] resp;
  assign in_get = state >= S_GET_AH && state <= S_GET_BL;
  assign bus.fpu_start = state == S_EXEC;
  assign bus.busy = state != S_IDLE;
  seq_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_to (
    .clk(clk), .rst(rst), .clr(ev || !in_get), .en(in_get), .tc(tc)
  );
  // tx_data is a pure function of state so it is held for the whole handshake and drops to 0 on reset
  always_comb
    bus.tx_data = state == S_TX_RH  ? resp[2] :
                  state == S_TX_RL  ? resp[1] :
                  state == S_TX_FL  ? resp[0] :
                  state == S_TX_ERR ? ERR_BYTE : 8'h00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      rx_prev         <= 1'b0;
      ev              <= 1'b0;
      rx_byte         <= 8'h00;
      resp            <= '0;
      bus.fpu_op      <= OP_ADD;
      bus.fpu_a       <= 16'h0000;
      bus.fpu_b       <= 16'h0000;
      bus.tx_start    <= 1'b0;
      bus.err_timeout <= 1'b0;
      bus.err_overrun <= 1'b0;
    end else begin
      rx_prev         <= bus.rx_flag;
      ev              <= bus.rx_flag && !rx_prev;
      rx_byte         <= bus.rx_data;
      bus.tx_start    <= 1'b0;
      bus.err_timeout <= 1'b0;
      if (ev && state >= S_EXEC) bus.err_overrun <= 1'b1;
      // a byte arriving on the terminal count wins over the timeout
      if (in_get && !ev && tc) begin
        state           <= S_IDLE;
        bus.err_timeout <= 1'b1;
      end
      case (state)
        S_IDLE: if (ev) begin
          if (rx_byte[7:2] == 6'd0) begin
            bus.fpu_op      <= rx_byte[1:0];
            bus.err_overrun <= 1'b0;
            state           <= S_GET_AH;
          end else begin
            bus.tx_start <= 1'b1;
            state        <= S_TX_ERR;
          end
        end
        S_GET_AH: if (ev) begin bus.fpu_a[15:8] <= rx_byte; state <= S_GET_AL; end
        S_GET_AL: if (ev) begin bus.fpu_a[7:0]  <= rx_byte; state <= S_GET_BH; end
        S_GET_BH: if (ev) begin bus.fpu_b[15:8] <= rx_byte; state <= S_GET_BL; end
        S_GET_BL: if (ev) begin bus.fpu_b[7:0]  <= rx_byte; state <= S_EXEC; end
        S_EXEC: state <= S_WAIT_FPU;
        S_WAIT_FPU: if (bus.fpu_done) begin
          resp         <= {bus.fpu_result, 4'h0, bus.fpu_flags};
          bus.tx_start <= 1'b1;
          state        <= S_TX_RH;
        end
        S_TX_RH: if (bus.tx_done) begin bus.tx_start <= 1'b1; state <= S_TX_RL; end
        S_TX_RL: if (bus.tx_done) begin bus.tx_start <= 1'b1; state <= S_TX_FL; end
        S_TX_FL, S_TX_ERR: if (bus.tx_done) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fpu_uart_sequencer.sv
// tb_fpu_uart_sequencer: table-driven frames with FPU/UART responders and a tx byte scoreboard
module tb_fpu_uart_sequencer;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  fpu_uart_sequencer_if bus();
  fpu_uart_sequencer #(.TIMEOUT_CYC(16), .ERR_BYTE(8'hEE)) dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {
    logic [7:0]  op;
    logic [15:0] a, b, res;
    logic [3:0]  fl;
  } vec_t;
  vec_t vecs[4];
  vec_t fq[$];
  logic [7:0] tq[$];
  int total = 0, bad = 0, tx_cnt = 0, fpu_cnt = 0, start_cyc = 0, to_cyc = 0, fpu_lat = 3;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic check_zero(string name);
    chk({name, " ctl"}, {bus.busy, bus.fpu_start, bus.tx_start, bus.err_timeout, bus.err_overrun, bus.fpu_op, bus.tx_data}, 0);
    chk({name, " fpu_a"}, bus.fpu_a, 0);
    chk({name, " fpu_b"}, bus.fpu_b, 0);
  endtask

  task automatic push_exp(vec_t v);
    fq.push_back(v);
    tq.push_back(v.res[15:8]);
    tq.push_back(v.res[7:0]);
    tq.push_back({4'h0, v.fl});
  endtask

  task automatic send_byte(logic [7:0] b, int hold = 1, int gap = 1);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_flag = 1;
    repeat (hold) @(negedge clk);
    bus.rx_flag = 0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame(vec_t v, int hold = 1, int gap = 1);
    push_exp(v);
    send_byte(v.op, hold, gap);
    send_byte(v.a[15:8], hold, gap);
    send_byte(v.a[7:0], hold, gap);
    send_byte(v.b[15:8], hold, gap);
    send_byte(v.b[7:0], hold, gap);
  endtask

  task automatic wait_idle(string name, int budget = 300);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, bus.busy, 0);
  endtask

  always @(negedge clk) begin
    if (bus.fpu_start) start_cyc++;
    if (bus.err_timeout) to_cyc++;
  end

  // FPU model: checks the launched operands against the expected frame, answers after fpu_lat cycles
  initial begin
    vec_t v;
    forever begin
      @(negedge clk);
      if (bus.fpu_start && !rst) begin
        fpu_cnt++;
        if (fq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL fpu_start with no expected frame");
        end else begin
          v = fq.pop_front();
          chk("fpu_op", bus.fpu_op, {30'd0, v.op[1:0]});
          chk("fpu_a", bus.fpu_a, v.a);
          chk("fpu_b", bus.fpu_b, v.b);
          repeat (fpu_lat) @(negedge clk);
          chk("fpu_a held", bus.fpu_a, v.a);
          bus.fpu_result = v.res;
          bus.fpu_flags  = v.fl;
          bus.fpu_done   = 1;
          @(negedge clk);
          bus.fpu_done = 0;
          chk("done to tx_start latency", bus.tx_start, 1);
        end
      end
    end
  end

  // UART tx model: scoreboard pop on every tx_start, tx_done two cycles later
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      while (bus.tx_start && !rst) begin
        tx_cnt++;
        if (tq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected tx byte got %0h", bus.tx_data);
        end else begin
          e = tq.pop_front();
          chk("tx_data", bus.tx_data, e);
        end
        @(negedge clk);
        chk("tx_start one cycle", bus.tx_start, 0);
        @(negedge clk);
        bus.tx_done = 1;
        @(negedge clk);
        bus.tx_done = 0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, base;
    bus.rx_flag = 0; bus.rx_data = 0; bus.fpu_done = 0;
    bus.fpu_result = 0; bus.fpu_flags = 0; bus.tx_done = 0;
    vecs[0] = '{8'h00, 16'h3C00, 16'h4000, 16'h4200, 4'h0};
    vecs[1] = '{8'h01, 16'h1234, 16'h00FF, 16'h1135, 4'h1};
    vecs[2] = '{8'h02, 16'hFFFF, 16'h8000, 16'hABCD, 4'hA};
    vecs[3] = '{8'h03, 16'h0001, 16'hFFFE, 16'h7C00, 4'hF};
    rst = 1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 0;

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i]);
      wait_idle("frame idle");
    end
    chk("fpu launches", fpu_cnt, 4);
    chk("fpu_start cycles", start_cyc, 4);
    chk("tx bytes", tx_cnt, 12);
    chk("no spurious timeout", to_cyc, 0);

    bus.fpu_done = 1;
    @(negedge clk);
    bus.fpu_done = 0;
    repeat (3) @(negedge clk);
    chk("stray fpu_done busy", bus.busy, 0);
    chk("stray fpu_done tx", tx_cnt, 12);

    tq.push_back(8'hEE);
    send_byte(8'h07);
    chk("illegal busy", bus.busy, 1);
    wait_idle("illegal idle");
    tq.push_back(8'hEE);
    send_byte(8'h80);
    wait_idle("illegal idle 2");
    chk("illegal no launch", fpu_cnt, 4);
    chk("illegal tx count", tx_cnt, 14);

    base = to_cyc;
    send_byte(8'h01);
    n = 0;
    while (!bus.err_timeout && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("timeout pulse", bus.err_timeout, 1);
    chk("timeout delay in range", (n >= 15 && n <= 17), 1);
    chk("timeout idle", bus.busy, 0);
    @(negedge clk);
    chk("timeout one cycle", to_cyc - base, 1);
    send_frame(vecs[1], 1, 12);
    wait_idle("slow frame idle");
    chk("slow frame no timeout", to_cyc - base, 1);
    chk("slow frame launch", fpu_cnt, 5);

    fpu_lat = 20;
    base = fpu_cnt;
    send_frame(vecs[2]);
    n = 0;
    while (fpu_cnt == base && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("overrun launch", fpu_cnt, base + 1);
    send_byte(8'h55);
    chk("overrun set", bus.err_overrun, 1);
    chk("overrun busy", bus.busy, 1);
    wait_idle("overrun idle");
    chk("overrun sticky", bus.err_overrun, 1);
    fpu_lat = 3;
    push_exp(vecs[3]);
    send_byte(vecs[3].op);
    chk("overrun cleared", bus.err_overrun, 0);
    send_byte(vecs[3].a[15:8]);
    send_byte(vecs[3].a[7:0]);
    send_byte(vecs[3].b[15:8]);
    send_byte(vecs[3].b[7:0]);
    wait_idle("post overrun idle");

    send_frame(vecs[0], 3, 1);
    wait_idle("stretched idle");
    chk("stretched launches", fpu_cnt, base + 3);

    base = tx_cnt;
    send_frame(vecs[1]);
    n = 0;
    while (tx_cnt < base + 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reached second tx byte", tx_cnt, base + 2);
    rst = 1;
    @(posedge clk);
    #1;
    check_zero("reset mid tx");
    @(negedge clk);
    rst = 0;
    repeat (20) @(negedge clk);
    chk("no tx after reset", tx_cnt, base + 2);
    chk("idle after reset", bus.busy, 0);
    tq.delete();

    send_frame(vecs[3]);
    wait_idle("recovery idle");
    chk("tx queue drained", tq.size(), 0);
    chk("fpu queue drained", fq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
